// File: rtl/window_scheduler.sv
// window_scheduler: paces pixels into a double line buffer and raises a
// 3x3 window strobe for every stride-aligned window position of the frame.
// Ports: clk, reset (sync, active high); start/busy/frame_done frame control;
// in_valid/in_ready pixel handshake; lb_push/lb_clear line-buffer control;
// win_valid/out_ready window handshake; row/col next pixel; win_count windows.
// Build option WIN_SCHED_BACKPRESSURE_EN: adds out_ready. Without it, windows
// are one-cycle pulses and in_ready is high for the whole LOAD state.
`timescale 1ns/1ps
module window_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 4,
  parameter int STRIDE     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          frame_done,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          lb_push,
  output logic                          lb_clear,
  output logic                          win_valid,
`ifdef WIN_SCHED_BACKPRESSURE_EN
  input  logic                          out_ready,
`endif
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [15:0]                   win_count
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  // Pixel data never passes through here; DATA_WIDTH only documents the
  // companion datapath, so it is just range-checked with the geometry.
  if (DATA_WIDTH < 1 || IMG_WIDTH < 3 || IMG_HEIGHT < 3 ||
      (STRIDE != 1 && STRIDE != 2)) begin : g_param_check
    $error("window_scheduler: unsupported parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;

`ifndef WIN_SCHED_BACKPRESSURE_EN
  logic out_ready;
  assign out_ready = 1'b1;
`endif

  logic qual;
  logic is_last;
  logic stride_ok;

  // With stride 2 the aligned positions are exactly the even ones, since
  // (r-2) and r share parity.
  assign stride_ok = (STRIDE == 1) || (!row[0] && !col[0]);
  assign qual      = (row >= RW'(2)) && (col >= CW'(2)) && stride_ok;
  assign is_last   = (row == ROW_LAST) && (col == COL_LAST);

  // A window still waiting for the consumer blocks intake, so no new
  // window can be produced before the pending one is taken.
  assign in_ready = (state == LOAD) && !(win_valid && !out_ready);
  assign lb_push  = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      win_count  <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      lb_clear   <= 1'b0;
    end else begin
      lb_clear   <= 1'b0;
      frame_done <= 1'b0;

      if (win_valid && out_ready && win_count != 16'hFFFF) begin
        win_count <= win_count + 16'd1;
      end

      // A push only happens when any pending window is being taken.
      if (lb_push) begin
        win_valid <= qual;
      end else if (out_ready) begin
        win_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            lb_clear  <= 1'b1;
            row       <= '0;
            col       <= '0;
            win_count <= '0;
          end
        end
        LOAD: begin
          if (lb_push) begin
            if (is_last) begin
              state <= DONE;
              row   <= '0;
              col   <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DONE: begin
          if (!win_valid) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_scheduler.sv
// tb_window_scheduler: directed vector table for a 4x4 frame plus
// hand sequences for backpressure, mid-frame reset and a 6x6 stride-2 frame.
`timescale 1ns/1ps
module tb_window_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic reset, start, in_valid, out_ready;
  logic busy, frame_done, in_ready, lb_push, lb_clear, win_valid;
  logic [1:0]  row, col;
  logic [15:0] win_count;

  logic start6, iv6, or6;
  logic busy6, fd6, ir6, push6, clr6, wv6;
  logic [2:0]  row6, col6;
  logic [15:0] wc6;

  window_scheduler #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .STRIDE(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .in_valid(in_valid), .in_ready(in_ready),
    .lb_push(lb_push), .lb_clear(lb_clear), .win_valid(win_valid),
`ifdef WIN_SCHED_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .row(row), .col(col), .win_count(win_count)
  );

  window_scheduler #(
    .DATA_WIDTH(8), .IMG_WIDTH(6), .IMG_HEIGHT(6), .STRIDE(2)
  ) dut6 (
    .clk(clk), .reset(reset), .start(start6), .busy(busy6),
    .frame_done(fd6), .in_valid(iv6), .in_ready(ir6),
    .lb_push(push6), .lb_clear(clr6), .win_valid(wv6),
`ifdef WIN_SCHED_BACKPRESSURE_EN
    .out_ready(or6),
`endif
    .row(row6), .col(col6), .win_count(wc6)
  );

  logic or_eff;
`ifdef WIN_SCHED_BACKPRESSURE_EN
  assign or_eff = out_ready;
`else
  assign or_eff = 1'b1;
`endif

  int cyc = 0;
  int n_push = 0, n_win = 0, n_fd = 0, n_clr = 0;
  int first_push = -1, last_push = -1;
  int n6_push = 0;
  int prev6 = 0;
  int pos6[$];

  always @(posedge clk) begin
    cyc++;
    if (lb_push) begin
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
      n_push++;
    end
    if (win_valid && or_eff) n_win++;
    if (frame_done) n_fd++;
    if (lb_clear) n_clr++;
    if (wv6) pos6.push_back(prev6);
    if (push6) begin
      prev6 = int'(row6) * 10 + int'(col6);
      n6_push++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic st, iv, ordy;
    logic ir, push, clr, wv, bsy, fd;
    int r, c, wc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, iv, ordy, ir, push, clr, wv, bsy, fd,
                     input int r, c, wc);
    tbl.push_back('{st, iv, ordy, ir, push, clr, wv, bsy, fd, r, c, wc});
  endtask

  task automatic run_frame(input string tag, input int stall);
    logic seen_fd = 1'b0;
    logic stall_done = 1'b0;
    int wc_at_fd = -1;
    n_push = 0; n_win = 0; n_fd = 0; n_clr = 0;
    first_push = -1; last_push = -1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 200 && !seen_fd; k++) begin
      if (stall > 0 && !stall_done && win_valid) begin
        for (int s = 0; s < stall; s++) begin
          out_ready = 1'b0;
          #1;
          chk({tag, ".stall_in_ready"}, in_ready, 0);
          chk({tag, ".stall_win_held"}, win_valid, 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
        stall_done = 1'b1;
        chk({tag, ".win_after_stall"}, win_valid, 1);
      end
      #1;
      if (frame_done) begin
        seen_fd = 1'b1;
        wc_at_fd = win_count;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, ".frame_done_seen"}, seen_fd, 1);
    repeat (3) @(negedge clk);
    chk({tag, ".pushes"}, n_push, 16);
    chk({tag, ".push_span"}, last_push - first_push, 15 + stall);
    chk({tag, ".windows"}, n_win, 4);
    chk({tag, ".frame_done_count"}, n_fd, 1);
    chk({tag, ".lb_clear_count"}, n_clr, 1);
    chk({tag, ".win_count_at_done"}, wc_at_fd, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp6[4];
    logic seen6;
    int wc6_at_fd;
    exp6 = '{22, 24, 42, 44};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    start6 = 1'b0; iv6 = 1'b0; or6 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.win_valid", win_valid, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.lb_clear", lb_clear, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.row", row, 0);
    chk("rst.col", col, 0);
    chk("rst.win_count", win_count, 0);
    reset = 1'b0;

    //   st iv or | ir pu cl wv bs fd | r c wc
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1,  1, 1, 1, 0, 1, 0,  0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  0, 1, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  0, 2, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  0, 3, 0);
    add(1, 1, 1,  1, 1, 0, 0, 1, 0,  1, 0, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  1, 1, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  1, 2, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  1, 3, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  2, 0, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  2, 1, 0);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  2, 2, 0);
    add(0, 1, 1,  1, 1, 0, 1, 1, 0,  2, 3, 0);
    add(0, 1, 1,  1, 1, 0, 1, 1, 0,  3, 0, 1);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  3, 1, 2);
    add(0, 1, 1,  1, 1, 0, 0, 1, 0,  3, 2, 2);
    add(0, 1, 1,  1, 1, 0, 1, 1, 0,  3, 3, 2);
    add(1, 1, 1,  0, 0, 0, 1, 1, 0,  0, 0, 3);
    add(0, 0, 1,  0, 0, 0, 0, 1, 0,  0, 0, 4);
    add(0, 1, 1,  0, 0, 0, 0, 0, 1,  0, 0, 4);
    add(0, 0, 1,  0, 0, 0, 0, 0, 0,  0, 0, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("v%0d.in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("v%0d.lb_push", i), lb_push, tbl[i].push);
      chk($sformatf("v%0d.lb_clear", i), lb_clear, tbl[i].clr);
      chk($sformatf("v%0d.win_valid", i), win_valid, tbl[i].wv);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d.frame_done", i), frame_done, tbl[i].fd);
      chk($sformatf("v%0d.row", i), row, tbl[i].r);
      chk($sformatf("v%0d.col", i), col, tbl[i].c);
      chk($sformatf("v%0d.win_count", i), win_count, tbl[i].wc);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);

`ifdef WIN_SCHED_BACKPRESSURE_EN
    run_frame("bp", 3);
`else
    run_frame("plain", 0);
`endif

    n_push = 0; n_fd = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 50 && n_push < 9; k++) @(negedge clk);
    in_valid = 1'b0;
    chk("midrst.pushes_before", n_push, 9);
    chk("midrst.busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.row", row, 0);
    chk("midrst.col", col, 0);
    repeat (4) @(negedge clk);
    chk("midrst.no_frame_done", n_fd, 0);
    chk("midrst.still_idle", busy, 0);
    run_frame("midrst.refrm", 0);

    n6_push = 0; pos6.delete(); seen6 = 1'b0; wc6_at_fd = -1;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0; iv6 = 1'b1;
    for (int k = 0; k < 300 && !seen6; k++) begin
      #1;
      if (fd6) begin
        seen6 = 1'b1;
        wc6_at_fd = wc6;
      end
      @(negedge clk);
    end
    iv6 = 1'b0;
    chk("s2.frame_done_seen", seen6, 1);
    chk("s2.pushes", n6_push, 36);
    chk("s2.windows", pos6.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2.win%0d_pos", i),
          (pos6.size() > i) ? pos6[i] : -1, exp6[i]);
    end
    chk("s2.win_count", wc6_at_fd, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
